// File: rtl/pc_jump_pkg.sv
// Shared types and constants for the programmable PC jump table.
package pc_jump_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // An unprogrammed entry is a relative +1, i.e. a plain fall-through.
  localparam logic        EntryRstAbs = 1'b0;
  localparam int unsigned EntryRstVal = 1;

  // A relative add leaves the unsigned PC range when a non-negative offset
  // carries out, or a negative offset fails to carry (a borrow).
  function automatic logic rel_overflow(input logic offset_sign, input logic carry);
    return offset_sign ? ~carry : carry;
  endfunction

endpackage

// File: rtl/jump_table_mem.sv
// Jump entry storage: async-reset register array, one write port and one
// combinational read port. Each entry is {abs, val}.
module jump_table_mem
  import pc_jump_pkg::*;
#(
  parameter int unsigned PW = 8,
  parameter int unsigned IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [PW-1:0] wr_val,
  input  logic          wr_abs,
  input  logic [IW-1:0] rd_idx,
  output logic [PW-1:0] rd_val,
  output logic          rd_abs
);

  localparam int unsigned Depth = 1 << IW;

  logic [PW-1:0] val_q [Depth];
  logic          abs_q [Depth];

  // Registered write; reset restores every entry to fall-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        val_q[i] <= PW'(EntryRstVal);
        abs_q[i] <= EntryRstAbs;
      end
    end else if (wr_en) begin
      val_q[wr_idx] <= wr_val;
      abs_q[wr_idx] <= wr_abs;
    end
  end

  // Read sees the pre-write contents on a same-cycle collision.
  assign rd_val = val_q[rd_idx];
  assign rd_abs = abs_q[rd_idx];

endmodule

// File: rtl/pc_jump_table.sv
// Program counter with a run-time programmable jump table. Produces the next
// PC from sequential increment or a table-driven absolute/relative jump, and
// keeps a sticky error flag for out-of-range targets.
module pc_jump_table
  import pc_jump_pkg::*;
#(
  parameter int unsigned PW = 8,
  parameter int unsigned IW = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Jump,
  input  logic [IW-1:0] Ptr,
  input  logic          WrEn,
  input  logic [IW-1:0] WrIdx,
  input  logic [PW-1:0] WrVal,
  input  logic          WrAbs,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic          Err
);

  state_e        state_q;
  logic [PW-1:0] pc_q;
  logic          err_q;

  logic [PW-1:0] ent_val;
  logic          ent_abs;

  logic [PW:0]   rel_sum;
  logic [PW:0]   inc_sum;
  logic [PW-1:0] jump_pc;
  logic          jump_err;
  logic          inc_err;

  jump_table_mem #(
    .PW(PW),
    .IW(IW)
  ) u_mem (
    .clk    (Clk),
    .rst    (Reset),
    .wr_en  (WrEn),
    .wr_idx (WrIdx),
    .wr_val (WrVal),
    .wr_abs (WrAbs),
    .rd_idx (Ptr),
    .rd_val (ent_val),
    .rd_abs (ent_abs)
  );

  // Next-PC candidates with carry-based range detection.
  always_comb begin
    rel_sum  = {1'b0, pc_q} + {1'b0, ent_val};
    inc_sum  = {1'b0, pc_q} + (PW + 1)'(1);
    jump_pc  = ent_abs ? ent_val : rel_sum[PW-1:0];
    jump_err = ~ent_abs & rel_overflow(ent_val[PW-1], rel_sum[PW]);
    inc_err  = inc_sum[PW];
  end

  // Sequencer: state, PC and sticky error updated together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            state_q <= StRun;
            pc_q    <= '0;
            err_q   <= 1'b0;
          end
        end
        StRun: begin
          if (Stall) begin
            // hold everything
          end else if (Halt) begin
            state_q <= StDone;
          end else if (Jump) begin
            pc_q  <= jump_pc;
            err_q <= err_q | jump_err;
          end else begin
            pc_q  <= inc_sum[PW-1:0];
            err_q <= err_q | inc_err;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign PC      = pc_q;
  assign Running = (state_q == StRun);
  assign Done    = (state_q == StDone);
  assign Err     = err_q;

endmodule

// File: tb/tb_pc_jump_table.sv
// Scoreboard bench for pc_jump_table: the driver updates a behavioural model
// and queues the expected outputs; the monitor checks after every clock edge.
module tb_pc_jump_table;

  localparam int unsigned PW = 8;
  localparam int unsigned IW = 5;
  localparam int Depth = 1 << IW;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Halt = 1'b0;
  logic          Stall = 1'b0;
  logic          Jump = 1'b0;
  logic [IW-1:0] Ptr = '0;
  logic          WrEn = 1'b0;
  logic [IW-1:0] WrIdx = '0;
  logic [PW-1:0] WrVal = '0;
  logic          WrAbs = 1'b0;
  logic [PW-1:0] PC;
  logic          Running;
  logic          Done;
  logic          Err;

  pc_jump_table #(
    .PW(PW),
    .IW(IW)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Halt    (Halt),
    .Stall   (Stall),
    .Jump    (Jump),
    .Ptr     (Ptr),
    .WrEn    (WrEn),
    .WrIdx   (WrIdx),
    .WrVal   (WrVal),
    .WrAbs   (WrAbs),
    .PC      (PC),
    .Running (Running),
    .Done    (Done),
    .Err     (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int n;
    int pc;
    bit run;
    bit done;
    bit err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cycno = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = done.
  int m_mode;
  int m_pc;
  bit m_err;
  int t_val [Depth];
  bit t_abs [Depth];

  task automatic cyc(input bit rst, input bit st, input bit hl, input bit sl, input bit jp,
                     input int ptr, input bit wen, input int widx, input int wval,
                     input bit wabs);
    int tgt;
    int off;
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Halt = hl; Stall = sl; Jump = jp;
    Ptr = ptr[IW-1:0]; WrEn = wen; WrIdx = widx[IW-1:0];
    WrVal = wval[PW-1:0]; WrAbs = wabs;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_err = 0;
      for (int i = 0; i < Depth; i++) begin
        t_val[i] = 1; t_abs[i] = 0;
      end
    end else begin
      if (m_mode != 1) begin
        if (st) begin
          m_mode = 1; m_pc = 0; m_err = 0;
        end
      end else if (!sl) begin
        if (hl) begin
          m_mode = 2;
        end else if (jp) begin
          if (t_abs[ptr % Depth]) begin
            m_pc = t_val[ptr % Depth];
          end else begin
            off = t_val[ptr % Depth];
            if (off >= 128) off = off - 256;
            tgt = m_pc + off;
            if (tgt < 0 || tgt > 255) m_err = 1;
            m_pc = tgt & 255;
          end
        end else begin
          tgt = m_pc + 1;
          if (tgt > 255) m_err = 1;
          m_pc = tgt & 255;
        end
      end
      // Table update lands after the lookup above.
      if (wen) begin
        t_val[widx % Depth] = wval & 255;
        t_abs[widx % Depth] = wabs;
      end
    end
    cycno++;
    e.n = cycno; e.pc = m_pc; e.run = (m_mode == 1); e.done = (m_mode == 2); e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump_to(input int ptr);
    cyc(0, 0, 0, 0, 1, ptr, 0, 0, 0, 0);
  endtask

  task automatic write_ent(input int idx, input int val, input bit abs_e);
    cyc(0, 0, 0, 0, 0, 0, 1, idx, val, abs_e);
  endtask

  task automatic start_run();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare after every rising edge once an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (int'(PC) != e.pc || Running != e.run || Done != e.done || Err != e.err) begin
          bad++;
          $display("FAIL cycle%0d: got pc=%0d run=%0b done=%0b err=%0b, want pc=%0d run=%0b done=%0b err=%0b",
                   e.n, PC, Running, Done, Err, e.pc, e.run, e.done, e.err);
        end
      end
    end
  end

  initial begin
    do_reset();
    do_reset();

    // Sequential run from 0.
    start_run();
    repeat (5) idle_cyc();

    // Absolute and relative jumps programmed before a fresh start.
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // halt to DONE
    write_ent(3, 40, 1);
    write_ent(4, 256 - 11, 0);
    start_run();
    idle_cyc();
    idle_cyc();
    jump_to(3);
    jump_to(4);

    // Negative relative offset below zero sets Err, which sticks.
    write_ent(5, 256 - 18, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // halt
    start_run();
    repeat (5) idle_cyc();
    jump_to(5);
    repeat (3) idle_cyc();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // Start ignored in RUN
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    start_run();

    // Write/lookup collision on idx 7 uses the old fall-through entry.
    cyc(0, 0, 0, 0, 1, 7, 1, 7, 100, 1);
    jump_to(7);

    // Increment wrap 255 -> 0 sets Err.
    write_ent(0, 255, 1);
    jump_to(0);
    idle_cyc();
    idle_cyc();

    // Stall beats Halt; releasing Stall halts; Start resumes.
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    start_run();
    repeat (9) idle_cyc();
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    start_run();

    // Mid-run reset reinitialises the table.
    write_ent(2, 50, 1);
    jump_to(2);
    idle_cyc();
    do_reset();
    idle_cyc();
    start_run();
    jump_to(2);
    jump_to(3);

    // Random traffic, including occasional mid-run resets.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), int'($urandom_range(0, Depth - 1)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, Depth - 1)),
          int'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge Clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
